// File: rtl/hazard_pkg.sv
// Shared definitions for the decode-stage hazard scoreboard: MIPS opcode
// classes, register-file geometry and the hazard controller state encoding.
package hazard_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned CNT_W    = 3;   // flush cycle counter, FLUSH_CYCLES <= 7

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_op_classify.sv
// Combinational opcode classifier: which source operands an instruction reads
// and which register (if any) it writes.
// Ports:
//   instrD   in   32  decode-stage instruction
//   usesRs   out  1   instruction reads rs
//   usesRt   out  1   instruction reads rt
//   hasDest  out  1   instruction writes a register
//   dest     out  5   destination register (0 when hasDest=0)
module hazard_op_classify
    import hazard_pkg::*;
(
    input  logic [31:0]      instrD,
    output logic             usesRs,
    output logic             usesRt,
    output logic             hasDest,
    output logic [REG_W-1:0] dest
);

    // Immediate / shamt / funct bits play no role in hazard classification.
    logic unused_low_bits;
    assign unused_low_bits = ^instrD[10:0];

    always_comb begin
        usesRs  = 1'b0;
        usesRt  = 1'b0;
        hasDest = 1'b0;
        dest    = '0;
        unique case (instrD[31:26])
            OP_RTYPE: begin
                usesRs  = 1'b1;
                usesRt  = 1'b1;
                hasDest = 1'b1;
                dest    = instrD[15:11];
            end
            OP_BEQ, OP_SW: begin
                usesRs = 1'b1;
                usesRt = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                usesRs  = 1'b1;
                hasDest = 1'b1;
                dest    = instrD[20:16];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard controller: per-register pending-write counters decide
// whether the decode instruction may issue, and drive stall, bubble and
// branch-flush controls for the 5-stage pipeline.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   instrD, validD  decode instruction and its valid bit
//   branchTakenD    branch in decode resolved taken
//   wbEn, wbReg     writeback register-file write
//   flag1, flag2    rs / rt operand ready (combinational)
//   hazardDetected  decode instruction blocked (combinational)
//   stallF, stallD  hold PC / IF-ID and decode (combinational)
//   flushE          bubble into ID-EX (combinational)
//   flushD          squash IF-ID after a taken branch (registered)
//   issueD          decode instruction issued (combinational)
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned PEND_W       = 2,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instrD,
    input  logic             validD,
    input  logic             branchTakenD,
    input  logic             wbEn,
    input  logic [REG_W-1:0] wbReg,
    output logic             flag1,
    output logic             flag2,
    output logic             hazardDetected,
    output logic             stallF,
    output logic             stallD,
    output logic             flushE,
    output logic             flushD,
    output logic             issueD
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [PEND_W-1:0] pend [NUM_REGS];
    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;

    logic              uses_rs, uses_rt, has_dest;
    logic [REG_W-1:0]  dest, rs, rt;
    logic              rs_ready, rt_ready, sat_full, in_flush;
    logic [NUM_REGS-1:0] inc_vec, dec_vec;

    hazard_op_classify u_classify (
        .instrD  (instrD),
        .usesRs  (uses_rs),
        .usesRt  (uses_rt),
        .hasDest (has_dest),
        .dest    (dest)
    );

    assign rs = instrD[25:21];
    assign rt = instrD[20:16];

    // Operand readiness with same-cycle writeback bypass (write-before-read RF).
    always_comb begin
        rs_ready = (pend[rs] == '0) ||
                   ((pend[rs] == PEND_W'(1)) && wbEn && (wbReg == rs) && (rs != '0));
        rt_ready = (pend[rt] == '0) ||
                   ((pend[rt] == PEND_W'(1)) && wbEn && (wbReg == rt) && (rt != '0));
        sat_full = has_dest && (dest != '0) && (pend[dest] == PEND_MAX);
        in_flush = (state == FLUSH);
        hazardDetected = validD && !in_flush &&
                         ((uses_rs && !rs_ready) || (uses_rt && !rt_ready) || sat_full);
        issueD   = validD && !in_flush && !hazardDetected;
    end

    assign flag1  = rs_ready;
    assign flag2  = rt_ready;
    assign stallF = hazardDetected;
    assign stallD = hazardDetected;
    assign flushE = hazardDetected;

    // Per-register increment/decrement requests; r0 never tracked.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issueD && has_dest && !reset) begin
            inc_vec[dest] = 1'b1;
        end
        if (wbEn) begin
            dec_vec[wbReg] = 1'b1;
        end
        inc_vec[0] = 1'b0;
        dec_vec[0] = 1'b0;
    end

    // Pending-write counters; simultaneous inc/dec cancel, no underflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    pend[r] <= pend[r] + PEND_W'(1);
                end else if (dec_vec[r] && !inc_vec[r] && (pend[r] != '0)) begin
                    pend[r] <= pend[r] - PEND_W'(1);
                end
            end
        end
    end

    // Control FSM state register; flushD registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUN;
            cnt    <= '0;
            flushD <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            flushD <= (state_next == FLUSH);
        end
    end

    // Next-state logic. Branch outcome is only trusted when operands are ready.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            RUN: begin
                if (branchTakenD && !hazardDetected) begin
                    state_next = FLUSH;
                    cnt_next   = CNT_W'(FLUSH_CYCLES - 1);
                end else if (hazardDetected) begin
                    state_next = STALL;
                end
            end
            STALL: begin
                if (!hazardDetected) begin
                    state_next = RUN;
                end
            end
            FLUSH: begin
                if (cnt == '0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = RUN;
        endcase
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (PEND_W=2, FLUSH_CYCLES=3). Each vector
// is one clock cycle: inputs driven on the falling edge, outputs compared 1ns
// later, state advancing on the following rising edge.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instrD;
    logic        validD, branchTakenD, wbEn;
    logic [4:0]  wbReg;
    logic        flag1, flag2, hazardDetected, stallF, stallD, flushE, flushD, issueD;

    always #5 clk = ~clk;

    hazard_scoreboard #(.PEND_W(2), .FLUSH_CYCLES(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .instrD         (instrD),
        .validD         (validD),
        .branchTakenD   (branchTakenD),
        .wbEn           (wbEn),
        .wbReg          (wbReg),
        .flag1          (flag1),
        .flag2          (flag2),
        .hazardDetected (hazardDetected),
        .stallF         (stallF),
        .stallD         (stallD),
        .flushE         (flushE),
        .flushD         (flushD),
        .issueD         (issueD)
    );

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        br;
        logic        wbe;
        logic [4:0]  wbr;
        logic        rst;
        logic        f1;
        logic        f2;
        logic        hz;
        logic        iss;
        logic        fd;
    } vec_t;

    int checks = 0;
    int fails  = 0;

    function automatic logic [31:0] rtype(input int rd, input int rs, input int rt);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt);
        return {6'(op), 5'(rs), 5'(rt), 16'd1};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input logic valid, input logic br,
                                input logic wbe, input int wbr, input logic rst,
                                input logic f1, input logic f2, input logic hz,
                                input logic iss, input logic fd);
        vec_t v;
        v.instr = instr; v.valid = valid; v.br = br; v.wbe = wbe; v.wbr = 5'(wbr);
        v.rst = rst; v.f1 = f1; v.f2 = f2; v.hz = hz; v.iss = iss; v.fd = fd;
        return v;
    endfunction

    task automatic chk(input string tag, input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s %s: got %b expected %b", tag, nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        instrD = v.instr; validD = v.valid; branchTakenD = v.br;
        wbEn = v.wbe; wbReg = v.wbr; reset = v.rst;
        #1;
        chk(tag, "flag1", flag1, v.f1);
        chk(tag, "flag2", flag2, v.f2);
        chk(tag, "hazardDetected", hazardDetected, v.hz);
        chk(tag, "stallF", stallF, v.hz);
        chk(tag, "stallD", stallD, v.hz);
        chk(tag, "flushE", flushE, v.hz);
        chk(tag, "issueD", issueD, v.iss);
        chk(tag, "flushD", flushD, v.fd);
    endtask

    vec_t tbl[$];
    localparam logic [31:0] IDLE = 32'd0;

    initial begin
        reset = 1'b1; instrD = '0; validD = 1'b0; branchTakenD = 1'b0;
        wbEn = 1'b0; wbReg = '0;
        repeat (2) @(negedge clk);

        //                instr               v  br wbe wbr rst f1 f2 hz iss fd
        // back-to-back dependency through $5
        tbl.push_back(mk(itype(8, 0, 5),     1, 0, 0, 0,  0,  1, 1, 0, 1, 0));
        tbl.push_back(mk(rtype(6, 5, 5),     1, 0, 0, 0,  0,  0, 0, 1, 0, 0));
        tbl.push_back(mk(rtype(6, 5, 5),     1, 0, 1, 5,  0,  1, 1, 0, 1, 0));
        tbl.push_back(mk(rtype(8, 5, 5),     1, 0, 0, 0,  0,  1, 1, 0, 1, 0));
        // two writes to $7 in flight
        tbl.push_back(mk(itype(35, 1, 7),    1, 0, 0, 0,  0,  1, 1, 0, 1, 0));
        tbl.push_back(mk(itype(8, 2, 7),     1, 0, 0, 0,  0,  1, 0, 0, 1, 0));
        tbl.push_back(mk(rtype(10, 7, 0),    1, 0, 0, 0,  0,  0, 1, 1, 0, 0));
        tbl.push_back(mk(rtype(10, 7, 0),    1, 0, 1, 7,  0,  0, 1, 1, 0, 0));
        tbl.push_back(mk(rtype(10, 7, 0),    1, 0, 0, 0,  0,  0, 1, 1, 0, 0));
        tbl.push_back(mk(rtype(10, 7, 0),    1, 0, 1, 7,  0,  1, 1, 0, 1, 0));
        // saturate $9 (max 3 in flight)
        tbl.push_back(mk(rtype(9, 0, 0),     1, 0, 0, 0,  0,  1, 1, 0, 1, 0));
        tbl.push_back(mk(rtype(9, 0, 0),     1, 0, 0, 0,  0,  1, 1, 0, 1, 0));
        tbl.push_back(mk(rtype(9, 0, 0),     1, 0, 0, 0,  0,  1, 1, 0, 1, 0));
        tbl.push_back(mk(rtype(9, 0, 0),     1, 0, 0, 0,  0,  1, 1, 1, 0, 0));
        tbl.push_back(mk(IDLE,               0, 0, 1, 9,  0,  1, 1, 0, 0, 0));
        tbl.push_back(mk(rtype(9, 0, 0),     1, 0, 0, 0,  0,  1, 1, 0, 1, 0));
        tbl.push_back(mk(IDLE,               0, 0, 1, 9,  0,  1, 1, 0, 0, 0));
        tbl.push_back(mk(IDLE,               0, 0, 1, 9,  0,  1, 1, 0, 0, 0));
        tbl.push_back(mk(IDLE,               0, 0, 1, 9,  0,  1, 1, 0, 0, 0));
        // simultaneous issue and writeback on $4
        tbl.push_back(mk(itype(8, 0, 4),     1, 0, 0, 0,  0,  1, 1, 0, 1, 0));
        tbl.push_back(mk(itype(8, 0, 4),     1, 0, 1, 4,  0,  1, 1, 0, 1, 0));
        tbl.push_back(mk(rtype(11, 4, 0),    1, 0, 0, 0,  0,  0, 1, 1, 0, 0));
        tbl.push_back(mk(rtype(11, 4, 0),    1, 0, 1, 4,  0,  1, 1, 0, 1, 0));
        // writers of $0 never count, never saturate
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(rtype(0, 3, 3), 1, 0, 0, 0,  0,  1, 1, 0, 1, 0));
        // writeback to an idle register must not underflow
        tbl.push_back(mk(IDLE,               0, 0, 1, 3,  0,  1, 1, 0, 0, 0));
        tbl.push_back(mk(itype(35, 0, 3),    1, 0, 0, 0,  0,  1, 1, 0, 1, 0));
        tbl.push_back(mk(rtype(14, 3, 0),    1, 0, 0, 0,  0,  0, 1, 1, 0, 0));
        tbl.push_back(mk(IDLE,               0, 0, 1, 3,  0,  1, 1, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // taken branch: flushD for exactly 3 cycles, decode squashed meanwhile
        apply(mk(itype(4, 1, 2),   1, 1, 0, 0,  0, 1, 1, 0, 1, 0), "br_take");
        for (int i = 0; i < 3; i++)
            apply(mk(rtype(15, 0, 0), 1, 1, 0, 0, 0, 1, 1, 0, 0, 1), $sformatf("br_flush%0d", i));
        apply(mk(rtype(15, 0, 0),  1, 0, 0, 0,  0, 1, 1, 0, 1, 0), "br_after");
        // branch with unready operand is ignored, also when it clears in STALL
        apply(mk(itype(4, 15, 0),  1, 1, 0, 0,  0, 0, 1, 1, 0, 0), "br_stall");
        apply(mk(itype(4, 15, 0),  1, 1, 1, 15, 0, 1, 1, 0, 1, 0), "br_release");
        apply(mk(IDLE,             0, 0, 0, 0,  0, 1, 1, 0, 0, 0), "br_noflush");
        apply(mk(rtype(16, 15, 15),1, 0, 0, 0,  0, 1, 1, 0, 1, 0), "squash_noinc");

        // reset during STALL
        apply(mk(itype(8, 0, 20),  1, 0, 0, 0,  0, 1, 1, 0, 1, 0), "rs_w20");
        apply(mk(rtype(21, 20, 0), 1, 0, 0, 0,  0, 0, 1, 1, 0, 0), "rs_stall");
        apply(mk(rtype(21, 20, 0), 1, 0, 0, 0,  1, 0, 1, 1, 0, 0), "rs_reset");
        apply(mk(rtype(21, 20, 0), 1, 0, 0, 0,  0, 1, 1, 0, 1, 0), "rs_issue");
        // reset during FLUSH
        apply(mk(itype(4, 0, 0),   1, 1, 0, 0,  0, 1, 1, 0, 1, 0), "rf_br");
        apply(mk(rtype(22, 0, 0),  1, 0, 0, 0,  1, 1, 1, 0, 0, 1), "rf_reset");
        apply(mk(rtype(22, 0, 0),  1, 0, 0, 0,  0, 1, 1, 0, 1, 0), "rf_run");
        // issue during reset does not increment
        apply(mk(rtype(23, 0, 0),  1, 0, 0, 0,  1, 1, 1, 0, 1, 0), "rr_issue");
        apply(mk(rtype(24, 23, 23),1, 0, 0, 0,  0, 1, 1, 0, 1, 0), "rr_reader");

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
